// File: rtl/ninjin_mem_arb_if.sv
// Bus bundle between the three memory requesters (host, renkon, gobou),
// the ninjin_mem_arb arbiter and the single-port common buffer memory.
// The arbiter connects through the slave modport; the requester/memory
// side (ninjin top level or a bench) connects through the master modport.
interface ninjin_mem_arb_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
);
    // requester -> arbiter
    logic              h_req;
    logic              r_req;
    logic              g_req;
    logic              h_we;
    logic              r_we;
    logic              g_we;
    logic [AWIDTH-1:0] h_addr;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] g_addr;
    logic [DWIDTH-1:0] h_wdata;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] g_wdata;

    // arbiter -> requester
    logic              h_gnt;
    logic              r_gnt;
    logic              g_gnt;
    logic              h_rvalid;
    logic              r_rvalid;
    logic              g_rvalid;
    logic [DWIDTH-1:0] rdata;

    // arbiter <-> memory
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  h_req, r_req, g_req,
        input  h_we, r_we, g_we,
        input  h_addr, r_addr, g_addr,
        input  h_wdata, r_wdata, g_wdata,
        output h_gnt, r_gnt, g_gnt,
        output h_rvalid, r_rvalid, g_rvalid,
        output rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output h_req, r_req, g_req,
        output h_we, r_we, g_we,
        output h_addr, r_addr, g_addr,
        output h_wdata, r_wdata, g_wdata,
        input  h_gnt, r_gnt, g_gnt,
        input  h_rvalid, r_rvalid, g_rvalid,
        input  rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/ninjin_mem_arb.sv
// ninjin_mem_arb: shares the single-port common buffer between the host,
// renkon (conv engine) and gobou (FC engine). Ownership is handed out in
// windows of at most BURST beats whenever someone else is waiting; the host
// has priority, but never gets two windows back to back while an engine is
// pending, and renkon/gobou alternate on ties.
module ninjin_mem_arb #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12,
    parameter int BURST  = 16
) (
    input  logic             clk,
    input  logic             xrst,
    ninjin_mem_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_H = 2'd1,
        OWN_R = 2'd2,
        OWN_G = 2'd3
    } state_t;

    // last window owner among the engines: 0 = renkon, 1 = gobou
    localparam logic       LAST_R   = 1'b0;
    localparam logic       LAST_G   = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(BURST - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last_eng_q, last_eng_d;
    logic              h_rvalid_q, r_rvalid_q, g_rvalid_q;

    logic              own_req_s;
    logic              own_we_s;
    logic [AWIDTH-1:0] own_addr_s;
    logic [DWIDTH-1:0] own_wdata_s;
    logic              others_req_s;
    logic              beat_s;
    logic              release_s;
    logic              cand_h_s, cand_r_s, cand_g_s;

    // Select the current owner's request bundle and whether anyone else waits.
    always_comb begin
        own_req_s    = 1'b0;
        own_we_s     = 1'b0;
        own_addr_s   = '0;
        own_wdata_s  = '0;
        others_req_s = 1'b0;
        case (state_q)
            OWN_H: begin
                own_req_s    = bus.h_req;
                own_we_s     = bus.h_we;
                own_addr_s   = bus.h_addr;
                own_wdata_s  = bus.h_wdata;
                others_req_s = bus.r_req | bus.g_req;
            end
            OWN_R: begin
                own_req_s    = bus.r_req;
                own_we_s     = bus.r_we;
                own_addr_s   = bus.r_addr;
                own_wdata_s  = bus.r_wdata;
                others_req_s = bus.h_req | bus.g_req;
            end
            OWN_G: begin
                own_req_s    = bus.g_req;
                own_we_s     = bus.g_we;
                own_addr_s   = bus.g_addr;
                own_wdata_s  = bus.g_wdata;
                others_req_s = bus.h_req | bus.r_req;
            end
            default: begin
                own_req_s    = 1'b0;
                own_we_s     = 1'b0;
                own_addr_s   = '0;
                own_wdata_s  = '0;
                others_req_s = 1'b0;
            end
        endcase
    end

    // In an OWN state the grant is always up, so a beat is just the owner's req.
    assign beat_s    = own_req_s;
    // Release on a dropped req, or on the last beat of a window with contention.
    assign release_s = (state_q != IDLE) &&
                       (!own_req_s || (beat_s && (cnt_q == CNT_LAST) && others_req_s));

    // Next-owner candidates: the releasing owner never competes for the next window.
    assign cand_h_s = bus.h_req & (state_q != OWN_H);
    assign cand_r_s = bus.r_req & (state_q != OWN_R);
    assign cand_g_s = bus.g_req & (state_q != OWN_G);

    // Next state, engine round-robin pointer and beat counter.
    always_comb begin
        state_d    = state_q;
        last_eng_d = last_eng_q;
        cnt_d      = cnt_q;

        if ((state_q == IDLE) || release_s) begin
            if (cand_h_s) begin
                state_d = OWN_H;
            end else if (cand_r_s && cand_g_s) begin
                state_d = (last_eng_q == LAST_G) ? OWN_R : OWN_G;
            end else if (cand_r_s) begin
                state_d = OWN_R;
            end else if (cand_g_s) begin
                state_d = OWN_G;
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = state_q;
        end

        if (state_d == OWN_R) begin
            last_eng_d = LAST_R;
        end else if (state_d == OWN_G) begin
            last_eng_d = LAST_G;
        end else begin
            last_eng_d = last_eng_q;
        end

        // cnt saturates at BURST-1 when the owner has the memory to itself
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (beat_s && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            last_eng_q <= LAST_G;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_eng_q <= last_eng_d;
        end
    end

    // Flag which requester's read is returning on rdata next cycle.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            h_rvalid_q <= 1'b0;
            r_rvalid_q <= 1'b0;
            g_rvalid_q <= 1'b0;
        end else begin
            h_rvalid_q <= (state_q == OWN_H) && beat_s && !own_we_s;
            r_rvalid_q <= (state_q == OWN_R) && beat_s && !own_we_s;
            g_rvalid_q <= (state_q == OWN_G) && beat_s && !own_we_s;
        end
    end

    // Grants are a pure decode of the state so handover needs no extra cycle.
    assign bus.h_gnt = (state_q == OWN_H);
    assign bus.r_gnt = (state_q == OWN_R);
    assign bus.g_gnt = (state_q == OWN_G);

    assign bus.h_rvalid = h_rvalid_q;
    assign bus.r_rvalid = r_rvalid_q;
    assign bus.g_rvalid = g_rvalid_q;

    // Address/data follow the owner even on non-beats; only the write strobe is gated.
    assign bus.mem_we    = beat_s & own_we_s;
    assign bus.mem_addr  = own_addr_s;
    assign bus.mem_wdata = own_wdata_s;
    assign bus.rdata     = bus.mem_rdata;

endmodule
